d_stage_buf: RTL and testbench

Parametrised IF/ID boundary buffer replacing the single-entry decode pipeline register. Holds up to DEPTH fetched instructions (instruction word, PC, exception code) in a FIFO with valid/ready on the fetch side and stall/flush on the decode side. The FIFO head drives the decode stage and an all-zero NOP is presented when the buffer is empty. A saturating counter records cycles in which decode stalls on a valid instruction.

---
 rtl/d_stage_buf.sv | 101 ++++++++++
 tb/tb_d_stage_buf.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_stage_buf.sv
// IF/ID boundary buffer: DEPTH-entry FIFO between fetch and decode.
// Head drives decode; an all-zero NOP is shown when empty.
module d_stage_buf #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int EXC_W  = 5,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            instr_in,
  input  logic [PC_W-1:0]              pc_in,
  input  logic [EXC_W-1:0]             exc_in,
  input  logic                         stall,
  input  logic                         flush,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            instr_out,
  output logic [PC_W-1:0]              pc_out,
  output logic [EXC_W-1:0]             exc_out,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [CNT_W-1:0]             stall_cycles
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [PC_W-1:0]   pc_q    [DEPTH];
  logic [EXC_W-1:0]  exc_q   [DEPTH];

  logic [PW-1:0]    rp_q, rp_d;
  logic [PW-1:0]    wp_q, wp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stc_q, stc_d;

  logic enq;
  logic deq;

  // Ready depends on registered occupancy only: no pass-through when full.
  assign in_ready  = (cnt_q < CW'(DEPTH));
  assign out_valid = (cnt_q != '0);

  assign enq = in_valid & in_ready & ~flush;
  assign deq = out_valid & ~stall & ~flush;

  assign instr_out    = out_valid ? instr_q[rp_q] : '0;
  assign pc_out       = out_valid ? pc_q[rp_q]    : '0;
  assign exc_out      = out_valid ? exc_q[rp_q]   : '0;
  assign count        = cnt_q;
  assign stall_cycles = stc_q;

  always_comb begin
    rp_d  = rp_q;
    wp_d  = wp_q;
    cnt_d = cnt_q;
    stc_d = stc_q;
    if (flush) begin
      rp_d  = '0;
      wp_d  = '0;
      cnt_d = '0;
    end else begin
      if (enq)
        wp_d = wp_q + PW'(1);
      if (deq)
        rp_d = rp_q + PW'(1);
      if (enq & ~deq)
        cnt_d = cnt_q + CW'(1);
      else if (deq & ~enq)
        cnt_d = cnt_q - CW'(1);
    end
    if (out_valid & stall & ~flush & ~(&stc_q))
      stc_d = stc_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rp_q  <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
      stc_q <= '0;
    end else begin
      rp_q  <= rp_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      stc_q <= stc_d;
    end
  end

  // Payload storage needs no reset; occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_q[wp_q] <= instr_in;
      pc_q[wp_q]    <= pc_in;
      exc_q[wp_q]   <= exc_in;
    end
  end

endmodule

// File: tb/tb_d_stage_buf.sv
// Bench for d_stage_buf: DEPTH=2/CNT_W=4 and DEPTH=4/CNT_W=16
// instances share stimulus; each is checked against a queue model.
module tb_d_stage_buf;

  logic        clk = 0;
  logic        reset = 1;
  logic        in_valid = 0;
  logic [31:0] instr_in = 0;
  logic [31:0] pc_in = 0;
  logic [4:0]  exc_in = 0;
  logic        stall = 0;
  logic        flush = 0;

  logic        ir_a, ov_a, ir_b, ov_b;
  logic [31:0] io_a, po_a, io_b, po_b;
  logic [4:0]  eo_a, eo_b;
  logic [1:0]  cnt_a;
  logic [2:0]  cnt_b;
  logic [3:0]  sc_a;
  logic [15:0] sc_b;

  always #5 clk = ~clk;

  d_stage_buf #(.DEPTH(2), .CNT_W(4)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_a),
    .instr_in(instr_in), .pc_in(pc_in), .exc_in(exc_in),
    .stall(stall), .flush(flush), .out_valid(ov_a),
    .instr_out(io_a), .pc_out(po_a), .exc_out(eo_a),
    .count(cnt_a), .stall_cycles(sc_a)
  );

  d_stage_buf #(.DEPTH(4), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_b),
    .instr_in(instr_in), .pc_in(pc_in), .exc_in(exc_in),
    .stall(stall), .flush(flush), .out_valid(ov_b),
    .instr_out(io_b), .pc_out(po_b), .exc_out(eo_b),
    .count(cnt_b), .stall_cycles(sc_b)
  );

  wire [76:0] vec_a = {ov_a, ir_a, cnt_a, io_a, po_a, eo_a, sc_a};
  wire [89:0] vec_b = {ov_b, ir_b, cnt_b, io_b, po_b, eo_b, sc_b};

  typedef struct packed {
    logic [31:0] i;
    logic [31:0] p;
    logic [4:0]  e;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];
  int   sca = 0;
  int   scb = 0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO queues updated from the rules at each edge.
  always @(posedge clk) begin : mdl
    bit   v0, r0, v1, r1;
    ent_t e;
    e  = {instr_in, pc_in, exc_in};
    v0 = qa.size() != 0;
    r0 = qa.size() < 2;
    v1 = qb.size() != 0;
    r1 = qb.size() < 4;
    if (reset) begin
      qa.delete(); qb.delete();
      sca = 0; scb = 0;
    end else if (flush) begin
      qa.delete(); qb.delete();
    end else begin
      if (v0 && stall && sca < 15) sca++;
      if (v1 && stall && scb < 65535) scb++;
      if (v0 && !stall) void'(qa.pop_front());
      if (v1 && !stall) void'(qb.pop_front());
      if (in_valid && r0) qa.push_back(e);
      if (in_valid && r1) qb.push_back(e);
    end
  end

  function automatic logic [76:0] exp_a();
    ent_t h;
    h = (qa.size() != 0) ? qa[0] : '0;
    return {qa.size() != 0, qa.size() < 2, 2'(qa.size()),
            h.i, h.p, h.e, 4'(sca)};
  endfunction

  function automatic logic [89:0] exp_b();
    ent_t h;
    h = (qb.size() != 0) ? qb[0] : '0;
    return {qb.size() != 0, qb.size() < 4, 3'(qb.size()),
            h.i, h.p, h.e, 16'(scb)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; instr_in = 0; pc_in = 0; exc_in = 0;
    stall = 0; flush = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
    idle();
  endtask

  task automatic test_reset();
    reset = 1;
    in_valid = 1; instr_in = $urandom; pc_in = $urandom;
    stall = 1; flush = 1;
    tick(); tick();
    reset = 0;
    idle();
    tick();
    n_checks++;
    if (vec_a !== {1'b0, 1'b1, 75'd0}) begin
      n_fail++;
      $display("FAIL reset_a: got %h exp %h", vec_a, {1'b0, 1'b1, 75'd0});
    end
    n_checks++;
    if (vec_b !== {1'b0, 1'b1, 88'd0}) begin
      n_fail++;
      $display("FAIL reset_b: got %h exp %h", vec_b, {1'b0, 1'b1, 88'd0});
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1; instr_in = i; pc_in = 32'h3000 + 4 * i; exc_in = 0;
      tick();
      n_checks++;
      if (vec_a !== exp_a()) begin
        n_fail++;
        $display("FAIL stream_a beat %0d: got %h exp %h", i, vec_a, exp_a());
      end
      n_checks++;
      if (!ov_a || io_a !== i || po_a !== 32'h3000 + 4 * i || cnt_a > 1) begin
        n_fail++;
        $display("FAIL stream_head beat %0d: got v=%b i=%h pc=%h c=%0d exp i=%h",
                 i, ov_a, io_a, po_a, cnt_a, i);
      end
    end
    idle();
    tick();
    n_checks++;
    if (vec_a !== exp_a() || ov_a !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_drain: got %h exp %h", vec_a, exp_a());
    end
  endtask

  task automatic test_full_stall();
    logic [31:0] vals[3];
    logic [31:0] got[$];
    int          k;
    vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
    do_reset();
    stall = 1;
    for (int i = 0; i < 5; i++) begin
      k = (i < 2) ? i : 2;
      in_valid = 1; instr_in = vals[k]; pc_in = 32'h100 + k;
      tick();
      n_checks++;
      if (vec_a !== exp_a()) begin
        n_fail++;
        $display("FAIL full_stall_a cyc %0d: got %h exp %h", i, vec_a, exp_a());
      end
    end
    n_checks++;
    if (ir_a !== 1'b0 || cnt_a !== 2'd2 || sc_a !== 4'd4 || io_a !== 32'hA) begin
      n_fail++;
      $display("FAIL full_hold: got rdy=%b c=%0d sc=%0d h=%h exp 0 2 4 a",
               ir_a, cnt_a, sc_a, io_a);
    end
    stall = 0;
    k = 0;
    while (got.size() < 3 && k < 20) begin
      if (ov_a) got.push_back(io_a);
      if (in_valid && qa.size() < 2) begin
        tick();
        in_valid = 0;
      end else begin
        tick();
      end
      n_checks++;
      if (vec_a !== exp_a()) begin
        n_fail++;
        $display("FAIL release_a cyc %0d: got %h exp %h", k, vec_a, exp_a());
      end
      k++;
    end
    n_checks++;
    if (got.size() != 3) begin
      n_fail++;
      $display("FAIL release_timeout: got %0d beats exp 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (got[i] !== vals[i]) begin
          n_fail++;
          $display("FAIL release_order %0d: got %h exp %h", i, got[i], vals[i]);
        end
      end
    end
    idle();
  endtask

  task automatic test_flush();
    logic [3:0] sc_save;
    do_reset();
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; instr_in = 32'h11 + i; pc_in = 32'h200 + 4 * i;
      tick();
    end
    tick();
    sc_save = sc_a;
    flush = 1; in_valid = 1; instr_in = 32'h77; pc_in = 32'h777;
    tick();
    n_checks++;
    if (cnt_a !== 2'd0 || ov_a !== 1'b0 || sc_a !== sc_save || io_a !== 0) begin
      n_fail++;
      $display("FAIL flush_a: got c=%0d v=%b sc=%0d i=%h exp 0 0 %0d 0",
               cnt_a, ov_a, sc_a, io_a, sc_save);
    end
    n_checks++;
    if (vec_b !== exp_b()) begin
      n_fail++;
      $display("FAIL flush_b: got %h exp %h", vec_b, exp_b());
    end
    flush = 0; instr_in = 32'h88; pc_in = 32'h888;
    tick();
    n_checks++;
    if (vec_a !== exp_a() || io_a !== 32'h88 || cnt_a !== 2'd1) begin
      n_fail++;
      $display("FAIL flush_newhead: got %h exp %h", vec_a, exp_a());
    end
    idle();
  endtask

  task automatic test_wrap();
    logic [36:0] got[$];
    int          beat;
    int          cyc;
    bit          prev_st;
    do_reset();
    beat = 0; cyc = 0; prev_st = 0;
    while (got.size() < 10 && cyc < 300) begin
      if (beat < 10) begin
        in_valid = ($urandom_range(0, 3) != 0);
        instr_in = 32'h100 + beat + 1;
        pc_in    = $urandom;
        exc_in   = (beat + 1 == 5) ? 5'h0A : 5'h00;
      end else begin
        in_valid = 0;
      end
      stall   = prev_st ? 1'b0 : ($urandom_range(0, 2) == 0);
      prev_st = stall;
      if (ov_b && !stall) got.push_back({io_b, eo_b});
      if (in_valid && qb.size() < 4) beat++;
      tick();
      n_checks++;
      if (vec_b !== exp_b()) begin
        n_fail++;
        $display("FAIL wrap_b cyc %0d: got %h exp %h", cyc, vec_b, exp_b());
      end
      n_checks++;
      if (vec_a !== exp_a()) begin
        n_fail++;
        $display("FAIL wrap_a cyc %0d: got %h exp %h", cyc, vec_a, exp_a());
      end
      cyc++;
    end
    n_checks++;
    if (got.size() != 10) begin
      n_fail++;
      $display("FAIL wrap_timeout: got %0d beats exp 10", got.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        logic [36:0] ex;
        ex = {32'h100 + i + 1, (i + 1 == 5) ? 5'h0A : 5'h00};
        n_checks++;
        if (got[i] !== ex) begin
          n_fail++;
          $display("FAIL wrap_order %0d: got %h exp %h", i, got[i], ex);
        end
      end
    end
    idle();
  endtask

  task automatic test_saturate();
    do_reset();
    stall = 1; in_valid = 1; instr_in = 32'h55; pc_in = 32'h5500;
    tick();
    in_valid = 0;
    for (int i = 0; i < 20; i++) tick();
    n_checks++;
    if (sc_a !== 4'd15 || vec_a !== exp_a()) begin
      n_fail++;
      $display("FAIL saturate_a: got sc=%0d vec=%h exp 15 %h", sc_a, vec_a, exp_a());
    end
    n_checks++;
    if (sc_b !== 16'd20) begin
      n_fail++;
      $display("FAIL count_b: got %0d exp 20", sc_b);
    end
    reset = 1; in_valid = 1; instr_in = 32'h66;
    tick();
    n_checks++;
    if (vec_a !== {1'b0, 1'b1, 75'd0}) begin
      n_fail++;
      $display("FAIL midreset_a: got %h exp %h", vec_a, {1'b0, 1'b1, 75'd0});
    end
    n_checks++;
    if (vec_b !== {1'b0, 1'b1, 88'd0}) begin
      n_fail++;
      $display("FAIL midreset_b: got %h exp %h", vec_b, {1'b0, 1'b1, 88'd0});
    end
    reset = 0;
    idle();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full_stall();
    test_flush();
    test_wrap();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
